// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared types and constants for the SPI transaction sequencer
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HDR,
        ST_RX,
        ST_TX_WAIT,
        ST_TX_BYTE,
        ST_HOLD,
        ST_GAP
    } seq_state_t;

    typedef enum logic {
        GNT_RD,
        GNT_WR
    } grant_t;

    localparam logic       RW_READ   = 1'b1;
    localparam logic       RW_WRITE  = 1'b0;
    localparam logic [7:0] IDLE_FILL = 8'h00;

endpackage

// File: rtl/spi_txn_sequencer_if.sv
// rtl/spi_txn_sequencer_if.sv - start/done byte handshake between the sequencer and the SPI byte engine
interface spi_txn_sequencer_if;

    logic       Eng_Start;
    logic [7:0] Eng_Tx_Byte;
    logic       Eng_Done;
    logic [7:0] Eng_Rx_Byte;

    modport master (output Eng_Start, output Eng_Tx_Byte, input Eng_Done, input Eng_Rx_Byte);
    modport slave  (input Eng_Start, input Eng_Tx_Byte, output Eng_Done, output Eng_Rx_Byte);

endinterface

// File: rtl/spi_seq_arb.sv
// rtl/spi_seq_arb.sv - read/write frame arbiter; SPI_SEQ_RR_ARB_EN selects round-robin, else read-first
module spi_seq_arb
    import spi_seq_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   rd_req,
    input  logic   wr_req,
    input  logic   take,
    output grant_t grant
);

`ifdef SPI_SEQ_RR_ARB_EN
    grant_t last_gnt;

    // Reset to "write granted last" so the first contested grant goes to read.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= GNT_WR;
        end else if (take) begin
            last_gnt <= grant;
        end
    end

    always_comb begin
        grant = GNT_RD;
        if (rd_req && wr_req) begin
            grant = (last_gnt == GNT_RD) ? GNT_WR : GNT_RD;
        end else if (wr_req) begin
            grant = GNT_WR;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = clk ^ rst ^ take;

    always_comb begin
        grant = (rd_req || !wr_req) ? GNT_RD : GNT_WR;
    end
`endif

endmodule

// File: rtl/spi_txn_sequencer.sv
// rtl/spi_txn_sequencer.sv - frames read/write transactions onto a shared SPI byte engine
// Build option: SPI_SEQ_RR_ARB_EN (round-robin read/write arbitration inside spi_seq_arb).
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int RX_BYTES     = 15,
    parameter int TX_MAX_BYTES = 15,
    parameter int TX_TIMEOUT   = 1024,
    parameter int CS_SETUP     = 4,
    parameter int CS_GAP       = 8
) (
    input  logic                  Mclk,
    input  logic                  Reset,
    input  logic [6:0]            Address,
    input  logic                  Read_RQ,
    input  logic                  Data_Available,
    input  logic [7:0]            BUS_IN,
    output logic [8*RX_BYTES-1:0] BUS_OUT,
    output logic                  Rx_Valid,
    output logic                  Tx_Ack,
    output logic                  Tx_Overrun,
    output logic                  Busy,
    output logic                  SPI_CS,
    spi_txn_sequencer_if.master   eng
);

    localparam int CW = $clog2(TX_TIMEOUT + 1);
    localparam int BW = $clog2(((RX_BYTES > TX_MAX_BYTES) ? RX_BYTES : TX_MAX_BYTES) + 1);

    logic                  rd_q, rd_q2, dav_q, dav_q2;
    logic [7:0]            bus_in_q;
    logic [6:0]            addr_q;
    logic                  rd_edge, dav_edge, capture;
    logic                  rd_pend, wr_pend, hold_full;
    logic [7:0]            hold;
    seq_state_t            state, state_n;
    grant_t                gnt, gnt_n, arb_gnt;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BW-1:0]         nbytes, nbytes_n;
    logic [8*RX_BYTES-1:0] shadow, shadow_n, bus_out_n;
    logic                  cs_n, start_n, rx_valid_n, take, send, rd_clr, wr_clr;
    logic [7:0]            txb_n;

    assign rd_edge  = rd_q & ~rd_q2;
    assign dav_edge = dav_q & ~dav_q2;
    assign capture  = dav_edge & ~hold_full;
    assign Busy     = (state != ST_IDLE);

    always_ff @(posedge Mclk) begin
        if (Reset) begin
            rd_q     <= 1'b0;
            rd_q2    <= 1'b0;
            dav_q    <= 1'b0;
            dav_q2   <= 1'b0;
            bus_in_q <= '0;
            addr_q   <= '0;
        end else begin
            rd_q     <= Read_RQ;
            rd_q2    <= rd_q;
            dav_q    <= Data_Available;
            dav_q2   <= dav_q;
            bus_in_q <= BUS_IN;
            addr_q   <= Address;
        end
    end

    // New requests win over same-cycle clears so an edge is never lost.
    always_ff @(posedge Mclk) begin
        if (Reset) begin
            rd_pend    <= 1'b0;
            wr_pend    <= 1'b0;
            hold_full  <= 1'b0;
            hold       <= '0;
            Tx_Ack     <= 1'b0;
            Tx_Overrun <= 1'b0;
        end else begin
            Tx_Ack     <= capture;
            Tx_Overrun <= dav_edge & hold_full;
            if (capture) begin
                hold      <= bus_in_q;
                hold_full <= 1'b1;
            end else if (send) begin
                hold_full <= 1'b0;
            end
            if (rd_edge)     rd_pend <= 1'b1;
            else if (rd_clr) rd_pend <= 1'b0;
            if (capture)     wr_pend <= 1'b1;
            else if (wr_clr) wr_pend <= 1'b0;
        end
    end

    spi_seq_arb u_arb (
        .clk    (Mclk),
        .rst    (Reset),
        .rd_req (rd_pend),
        .wr_req (wr_pend),
        .take   (take),
        .grant  (arb_gnt)
    );

    always_ff @(posedge Mclk) begin
        if (Reset) begin
            state           <= ST_IDLE;
            SPI_CS          <= 1'b1;
            eng.Eng_Start   <= 1'b0;
            eng.Eng_Tx_Byte <= '0;
            cnt             <= '0;
            nbytes          <= '0;
            shadow          <= '0;
            BUS_OUT         <= '0;
            Rx_Valid        <= 1'b0;
            gnt             <= GNT_RD;
        end else begin
            state           <= state_n;
            SPI_CS          <= cs_n;
            eng.Eng_Start   <= start_n;
            eng.Eng_Tx_Byte <= txb_n;
            cnt             <= cnt_n;
            nbytes          <= nbytes_n;
            shadow          <= shadow_n;
            BUS_OUT         <= bus_out_n;
            Rx_Valid        <= rx_valid_n;
            gnt             <= gnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cs_n       = SPI_CS;
        start_n    = 1'b0;
        txb_n      = eng.Eng_Tx_Byte;
        cnt_n      = cnt;
        nbytes_n   = nbytes;
        shadow_n   = shadow;
        bus_out_n  = BUS_OUT;
        rx_valid_n = 1'b0;
        gnt_n      = gnt;
        take       = 1'b0;
        send       = 1'b0;
        rd_clr     = 1'b0;
        wr_clr     = 1'b0;
        case (state)
            ST_IDLE: if (rd_pend || wr_pend) begin
                take    = 1'b1;
                gnt_n   = arb_gnt;
                cs_n    = 1'b0;
                cnt_n   = '0;
                state_n = ST_SETUP;
            end
            ST_SETUP: if (cnt == CW'(CS_SETUP - 1)) begin
                start_n = 1'b1;
                txb_n   = {(gnt == GNT_RD) ? RW_READ : RW_WRITE, addr_q};
                state_n = ST_HDR;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            ST_HDR: if (eng.Eng_Done) begin
                nbytes_n = '0;
                if (gnt == GNT_RD) begin
                    start_n = 1'b1;
                    txb_n   = IDLE_FILL;
                    state_n = ST_RX;
                end else begin
                    cnt_n   = '0;
                    state_n = ST_TX_WAIT;
                end
            end
            ST_RX: if (eng.Eng_Done) begin
                shadow_n = {shadow[8*RX_BYTES-9:0], eng.Eng_Rx_Byte};
                if (nbytes == BW'(RX_BYTES - 1)) begin
                    bus_out_n  = shadow_n;
                    rx_valid_n = 1'b1;
                    rd_clr     = 1'b1;
                    state_n    = ST_HOLD;
                end else begin
                    nbytes_n = nbytes + 1'b1;
                    start_n  = 1'b1;
                end
            end
            ST_TX_WAIT: if (hold_full) begin
                send     = 1'b1;
                start_n  = 1'b1;
                txb_n    = hold;
                nbytes_n = nbytes + 1'b1;
                state_n  = ST_TX_BYTE;
            end else if (cnt == CW'(TX_TIMEOUT - 1)) begin
                wr_clr  = 1'b1;
                state_n = ST_HOLD;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            // A byte already waiting in hold keeps wr_pend so it opens the next frame.
            ST_TX_BYTE: if (eng.Eng_Done) begin
                if (nbytes == BW'(TX_MAX_BYTES)) begin
                    wr_clr  = ~hold_full;
                    state_n = ST_HOLD;
                end else begin
                    cnt_n   = '0;
                    state_n = ST_TX_WAIT;
                end
            end
            ST_HOLD: begin
                cs_n    = 1'b1;
                cnt_n   = '0;
                state_n = ST_GAP;
            end
            ST_GAP: if (cnt == CW'(CS_GAP - 1)) begin
                state_n = ST_IDLE;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb/tb_spi_txn_sequencer.sv - random-data bench with an engine model and frame-level scoreboard
module tb_spi_txn_sequencer;

    localparam int RX_BYTES     = 15;
    localparam int TX_MAX_BYTES = 15;
    localparam int TX_TIMEOUT   = 1024;
    localparam int CS_SETUP     = 4;
    localparam int CS_GAP       = 8;
    localparam int ENG_LAT      = 16;

    logic                  Mclk = 1'b0;
    logic                  Reset;
    logic [6:0]            Address;
    logic                  Read_RQ;
    logic                  Data_Available;
    logic [7:0]            BUS_IN;
    logic [8*RX_BYTES-1:0] BUS_OUT;
    logic                  Rx_Valid, Tx_Ack, Tx_Overrun, Busy, SPI_CS;

    spi_txn_sequencer_if eng_if ();

    spi_txn_sequencer #(
        .RX_BYTES     (RX_BYTES),
        .TX_MAX_BYTES (TX_MAX_BYTES),
        .TX_TIMEOUT   (TX_TIMEOUT),
        .CS_SETUP     (CS_SETUP),
        .CS_GAP       (CS_GAP)
    ) dut (
        .Mclk           (Mclk),
        .Reset          (Reset),
        .Address        (Address),
        .Read_RQ        (Read_RQ),
        .Data_Available (Data_Available),
        .BUS_IN         (BUS_IN),
        .BUS_OUT        (BUS_OUT),
        .Rx_Valid       (Rx_Valid),
        .Tx_Ack         (Tx_Ack),
        .Tx_Overrun     (Tx_Overrun),
        .Busy           (Busy),
        .SPI_CS         (SPI_CS),
        .eng            (eng_if)
    );

    always #5 Mclk = ~Mclk;

    int cyc = 0;
    always @(posedge Mclk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Scoreboard: frames as flat byte streams plus per-frame lengths.
    logic [7:0] exp_bytes[$];
    int         exp_lens[$];
    int         exp_open = 0;
    logic [7:0] act_bytes[$];
    int         act_lens[$];
    logic [7:0] rx_seen[$];
    int         rx_valid_cnt = 0, ack_cnt = 0, ovr_cnt = 0;
    int         cs_rise_cyc = -1, last_done_cyc = 0;

    // Engine model (Eng_Done ENG_LAT cycles after Eng_Start) and bus monitor.
    initial begin
        bit         busy;
        int         left;
        bit         in_frame;
        int         cur_len;
        logic [7:0] held_tx;
        logic [8*RX_BYTES-1:0] want;
        busy = 0; left = 0; in_frame = 0; cur_len = 0; held_tx = 0;
        eng_if.Eng_Done    = 1'b0;
        eng_if.Eng_Rx_Byte = 8'h00;
        forever begin
            @(negedge Mclk);
            eng_if.Eng_Done = 1'b0;
            if (Reset) begin
                busy     = 0;
                in_frame = 0;
                rx_seen.delete();
            end else begin
                if (busy) begin
                    left--;
                    if (left == 0) begin
                        busy = 0;
                        eng_if.Eng_Done    = 1'b1;
                        eng_if.Eng_Rx_Byte = 8'($urandom);
                        last_done_cyc      = cyc;
                        check("tx_stable", eng_if.Eng_Tx_Byte, held_tx);
                        if (in_frame) rx_seen.push_back(eng_if.Eng_Rx_Byte);
                    end
                end
                if (!SPI_CS && !in_frame) begin
                    in_frame = 1;
                    cur_len  = 0;
                    rx_seen.delete();
                    if (cs_rise_cyc >= 0) check("cs_gap", (cyc - cs_rise_cyc) >= CS_GAP, 1);
                end
                if (eng_if.Eng_Start) begin
                    check("start_while_busy", busy, 0);
                    check("start_in_frame", in_frame, 1);
                    busy    = 1;
                    left    = ENG_LAT;
                    held_tx = eng_if.Eng_Tx_Byte;
                    act_bytes.push_back(eng_if.Eng_Tx_Byte);
                    cur_len++;
                end
                if (SPI_CS && in_frame) begin
                    in_frame = 0;
                    act_lens.push_back(cur_len);
                    cs_rise_cyc = cyc;
                end
                if (Rx_Valid) begin
                    rx_valid_cnt++;
                    check("rx_count", rx_seen.size(), RX_BYTES + 1);
                    want = '0;
                    for (int i = 1; i <= RX_BYTES && i < rx_seen.size(); i++)
                        want = {want[8*RX_BYTES-9:0], rx_seen[i]};
                    check("bus_out", BUS_OUT, want);
                end
                if (Tx_Ack) ack_cnt++;
                if (Tx_Overrun) ovr_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Mclk);
        #1;
    endtask

    task automatic exp_push(input logic [7:0] b);
        exp_bytes.push_back(b);
        exp_open++;
    endtask

    task automatic exp_close();
        exp_lens.push_back(exp_open);
        exp_open = 0;
    endtask

    task automatic exp_read_frame(input logic [6:0] a);
        exp_push({1'b1, a});
        for (int i = 0; i < RX_BYTES; i++) exp_push(8'h00);
        exp_close();
    endtask

    task automatic pulse_dav(input logic [7:0] b);
        BUS_IN = b;
        Data_Available = 1'b1;
        tick(2);
        Data_Available = 1'b0;
        tick(2);
    endtask

    task automatic pulse_rd();
        Read_RQ = 1'b1;
        tick(2);
        Read_RQ = 1'b0;
        tick(2);
    endtask

    task automatic wait_frames(input int budget);
        int n;
        n = 0;
        while (act_lens.size() < exp_lens.size() && n < budget) begin
            tick(1);
            n++;
        end
        check("frame_wait", act_lens.size(), exp_lens.size());
        tick(CS_GAP + 4);
        check("idle_after", Busy, 0);
    endtask

    task automatic compare_frames();
        int el, al;
        logic [7:0] e, a;
        while (exp_lens.size() > 0) begin
            el = exp_lens.pop_front();
            al = 0;
            if (act_lens.size() > 0) al = act_lens.pop_front();
            check("frame_len", al, el);
            for (int i = 0; i < el; i++) begin
                e = exp_bytes.pop_front();
                a = ~e;
                if (i < al) a = act_bytes.pop_front();
                check("frame_byte", a, e);
            end
            for (int i = el; i < al; i++) void'(act_bytes.pop_front());
        end
        check("extra_frames", act_lens.size(), 0);
    endtask

    initial begin
        int t0, lat, rv0, ack0, ovr0, n, delta;
        logic [6:0] a;
        logic [7:0] d[16];

        Reset = 1'b1; Address = 7'h00; Read_RQ = 1'b0; Data_Available = 1'b0; BUS_IN = 8'h00;
        tick(3);
        check("rst_cs", SPI_CS, 1);
        check("rst_busy", Busy, 0);
        check("rst_bus_out", BUS_OUT, 0);
        check("rst_rx_valid", Rx_Valid, 0);
        check("rst_tx_ack", Tx_Ack, 0);
        check("rst_tx_ovr", Tx_Overrun, 0);
        check("rst_start", eng_if.Eng_Start, 0);
        check("rst_tx_byte", eng_if.Eng_Tx_Byte, 0);
        Reset = 1'b0;
        tick(2);

        // Read at 0x5A with request-to-start latency.
        Address = 7'h5A;
        rv0 = rx_valid_cnt;
        Read_RQ = 1'b1;
        t0 = cyc;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            tick(1);
            if (k == 2) Read_RQ = 1'b0;
            if (eng_if.Eng_Start) lat = cyc - t0;
        end
        check("rd_latency", lat, 3 + CS_SETUP);
        check("rd_hdr_byte", eng_if.Eng_Tx_Byte, 8'hDA);
        exp_read_frame(7'h5A);
        wait_frames(1000);
        compare_frames();
        check("rd_valid_pulses", rx_valid_cnt - rv0, 1);

        // Random-address reads.
        for (int r = 0; r < 2; r++) begin
            a = 7'($urandom);
            Address = a;
            rv0 = rx_valid_cnt;
            pulse_rd();
            exp_read_frame(a);
            wait_frames(1000);
            compare_frames();
            check("rnd_rd_valid", rx_valid_cnt - rv0, 1);
        end

        // Sparse write: three bytes 512 cycles apart share one frame, closed by the idle timeout.
        Address = 7'h5A;
        ack0 = ack_cnt; ovr0 = ovr_cnt;
        pulse_dav(8'h21); tick(508);
        pulse_dav(8'hBB); tick(508);
        pulse_dav(8'hC9);
        exp_push(8'h5A); exp_push(8'h21); exp_push(8'hBB); exp_push(8'hC9); exp_close();
        wait_frames(3000);
        delta = cs_rise_cyc - last_done_cyc;
        check("tx_close_dly", (delta >= TX_TIMEOUT && delta <= TX_TIMEOUT + 4) ? TX_TIMEOUT : delta, TX_TIMEOUT);
        compare_frames();
        check("wr_acks", ack_cnt - ack0, 3);
        check("wr_overruns", ovr_cnt - ovr0, 0);

        // Max frame: 16 random bytes split 15 + 1.
        a = 7'($urandom);
        Address = a;
        ack0 = ack_cnt; ovr0 = ovr_cnt;
        for (int i = 0; i < 16; i++) begin
            d[i] = 8'($urandom);
            pulse_dav(d[i]);
            tick(36);
        end
        exp_push({1'b0, a});
        for (int i = 0; i < TX_MAX_BYTES; i++) exp_push(d[i]);
        exp_close();
        exp_push({1'b0, a}); exp_push(d[15]); exp_close();
        wait_frames(4000);
        compare_frames();
        check("max_acks", ack_cnt - ack0, 16);
        check("max_overruns", ovr_cnt - ovr0, 0);

        // Overrun: second byte arrives while the first still sits in hold.
        a = 7'($urandom);
        Address = a;
        ack0 = ack_cnt; ovr0 = ovr_cnt;
        d[0] = 8'($urandom); d[1] = 8'($urandom);
        pulse_dav(d[0]);
        pulse_dav(d[1]);
        exp_push({1'b0, a}); exp_push(d[0]); exp_close();
        wait_frames(3000);
        compare_frames();
        check("ovr_acks", ack_cnt - ack0, 1);
        check("ovr_overruns", ovr_cnt - ovr0, 1);

        // Contention: read and write edges in the same cycle, twice.
        for (int r = 0; r < 2; r++) begin
            a = 7'($urandom);
            Address = a;
            d[0] = 8'($urandom);
            rv0 = rx_valid_cnt;
            BUS_IN = d[0];
            Read_RQ = 1'b1; Data_Available = 1'b1;
            tick(2);
            Read_RQ = 1'b0; Data_Available = 1'b0;
            tick(2);
            exp_read_frame(a);
            exp_push({1'b0, a}); exp_push(d[0]); exp_close();
            wait_frames(3000);
            compare_frames();
            check("cont_rd_valid", rx_valid_cnt - rv0, 1);
        end

        // Reset after the 5th payload byte of a read, then a clean read.
        a = 7'($urandom);
        Address = a;
        rv0 = rx_valid_cnt;
        Read_RQ = 1'b1;
        tick(2);
        Read_RQ = 1'b0;
        n = 0;
        while (rx_seen.size() < 6 && n < 500) begin
            tick(1);
            n++;
        end
        check("mid_rd_reach", rx_seen.size() >= 6, 1);
        Reset = 1'b1;
        tick(1);
        check("mid_rst_cs", SPI_CS, 1);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_bus_out", BUS_OUT, 0);
        check("mid_rst_rx_valid", Rx_Valid, 0);
        Reset = 1'b0;
        tick(40);
        check("mid_rst_no_valid", rx_valid_cnt - rv0, 0);
        check("mid_rst_no_frame", act_lens.size(), 0);
        act_bytes.delete();
        a = 7'($urandom);
        Address = a;
        pulse_rd();
        exp_read_frame(a);
        wait_frames(1000);
        compare_frames();
        check("post_rst_valid", rx_valid_cnt - rv0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
